// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
//   Shared definitions for the period meter and its input conditioning.
//   - pm_state_e      : measurement FSM states (ARM, SEEK, RUN, LOST)
//   - DEF_SYNC_STAGES : default synchronizer depth for asynchronous inputs
//   - DEF_TIMEOUT     : default number of clk cycles without a rise before
//                       the input is declared lost
//   - ARM_SETTLE_EXTRA: extra cycles ARM waits beyond the synchronizer depth
//                       before it trusts the synchronized level
// -----------------------------------------------------------------------------
package period_meter_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2,
        LOST = 2'd3
    } pm_state_e;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_TIMEOUT      = 100_000_000;
    localparam int ARM_SETTLE_EXTRA = 1;

endpackage : period_meter_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous level into the clk domain through a chain of
//   SYNC_STAGES flops and derives single-cycle rise/fall pulses from it.
//   Reusable for slow external inputs such as buttons and switches.
//
// Parameters
//   SYNC_STAGES : synchronizer depth, must be >= 2
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high; clears every flop to 0
//   d_async in   asynchronous input level
//   s       out  synchronized level
//   rise    out  1 for one cycle when s goes 0 -> 1
//   fall    out  1 for one cycle when s goes 1 -> 0
//
// An edge on d_async shows up on rise/fall SYNC_STAGES+1 clk edges later,
// give or take one cycle of sampling uncertainty. rise and fall are
// mutually exclusive because both are decoded from the same (s, p) pair.
// -----------------------------------------------------------------------------
import period_meter_pkg::*;

module sync_edge_det #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // New sample enters at bit 0, the synchronized level leaves at the MSB.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule : sync_edge_det

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//   Measures a slow square wave in system clk cycles. For every full input
//   cycle it reports the period (rise to rise) and the high time (rise to
//   the following fall) together with a one-cycle valid strobe, and flags
//   loss of signal when no rise arrives within TIMEOUT cycles.
//
// Parameters
//   CNT_W       : width of the interval counter and period/high_time outputs
//   SYNC_STAGES : synchronizer depth on sig_in (>= 2)
//   TIMEOUT     : cycles without a rise before the signal is lost
//                 (2 < TIMEOUT < 2**CNT_W)
//   EDGE_W      : width of the measurement counter meas_cnt
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   sig_in    in   asynchronous signal under measurement
//   period    out  clk cycles between the last two detected rises
//   high_time out  clk cycles from a rise to the following fall within the
//                  last measured period (0 when no fall was seen)
//   valid     out  one-cycle strobe when period/high_time update
//   timeout   out  level, high while the signal is considered lost
//   meas_cnt  out  number of valid strobes issued, wraps at 2**EDGE_W
//
// Output protocol: valid is a pure strobe with no back-pressure. period,
// high_time and meas_cnt change only on the cycle valid is high and hold
// their values otherwise (including through LOST), so a consumer may
// either capture on valid or read the held values at any time.
//
// FSM: ARM -> SEEK -> RUN <-> LOST. The state register state_q is kept as
// a plain 2-bit vector so it can be observed and bound to directly.
// -----------------------------------------------------------------------------
import period_meter_pkg::*;

module period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int EDGE_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              valid,
    output logic              timeout,
    output logic [EDGE_W-1:0] meas_cnt
);

    // -------------------------------------------------------------------------
    // State encodings and constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_ARM  = ARM;
    localparam logic [1:0] ST_SEEK = SEEK;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_LOST = LOST;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  SETTLE_C  = CNT_W'(SYNC_STAGES + ARM_SETTLE_EXTRA);
    localparam logic [EDGE_W-1:0] MC_ONE    = EDGE_W'(1);

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    logic s;
    logic rise;
    logic fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .reset   (reset),
        .d_async (sig_in),
        .s       (s),
        .rise    (rise),
        .fall    (fall)
    );

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;     // cycles since the last rise
    logic [CNT_W-1:0]  hi_q,     hi_d;      // high time latched at the fall
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q,   high_d;
    logic              valid_q,  valid_d;
    logic              tmo_q,    tmo_d;
    logic [EDGE_W-1:0] mcnt_q,   mcnt_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        tmo_d    = tmo_q;
        mcnt_d   = mcnt_q;

        case (state_q)
            // The synchronizer flops are cleared by reset, so s reads 0 for
            // a few cycles after release even when sig_in is high. cnt is
            // reused as a settle counter so that ARM only trusts s once the
            // chain has refilled with the real input level; otherwise a high
            // level at reset release would look like a first rise.
            ST_ARM: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!s) begin
                    cnt_d   = '0;
                    state_d = ST_SEEK;
                end
            end

            // First rise only opens an interval; nothing to report yet.
            ST_SEEK: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    hi_d    = '0;
                    state_d = ST_RUN;
                end
            end

            // A rise closes the interval even when cnt has just reached
            // TIMEOUT, so a period of exactly TIMEOUT is still measured.
            ST_RUN: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                    mcnt_d   = mcnt_q + MC_ONE;
                    cnt_d    = CNT_ONE;
                    hi_d     = '0;
                end else begin
                    if (fall) begin
                        hi_d = cnt_q;
                    end
                    // cnt stops at TIMEOUT, so it can never wrap.
                    if (cnt_q == TIMEOUT_C) begin
                        tmo_d   = 1'b1;
                        state_d = ST_LOST;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // The rise that ends LOST restarts timing but does not report:
            // the interval before it is not a real period.
            ST_LOST: begin
                if (rise) begin
                    tmo_d   = 1'b0;
                    cnt_d   = CNT_ONE;
                    hi_d    = '0;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_ARM;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ARM;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            mcnt_q   <= mcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = tmo_q;
    assign meas_cnt  = mcnt_q;

endmodule : period_meter

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//   Directed bench for period_meter (TIMEOUT=20, EDGE_W=3). The driver issues
//   sig_in edges on the falling clock edge and pushes the hand-derived
//   measurement expected for each rise into exp_q; an independent monitor
//   pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_period_meter;

    localparam int CNT_W   = 32;
    localparam int SYNC    = 2;
    localparam int TMO     = 20;
    localparam int EDGE_W  = 3;
    localparam int EXP_W   = 2 * CNT_W + EDGE_W;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sig_in = 1'b0;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              valid;
    logic              timeout;
    logic [EDGE_W-1:0] meas_cnt;

    always #5 clk = ~clk;

    period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO),
        .EDGE_W      (EDGE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .meas_cnt  (meas_cnt)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [EXP_W-1:0]  exp_q[$];
    logic [EDGE_W-1:0] exp_mc = '0;
    int                tests_run = 0;
    int                tests_failed = 0;
    int                tmo_rises = 0;
    logic [CNT_W-1:0]  last_per = '0;
    logic [CNT_W-1:0]  last_hi = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks (all called at a falling clock edge)
    // -------------------------------------------------------------------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int per, input int hi);
        exp_mc = exp_mc + 1'b1;
        exp_q.push_back({CNT_W'(per), CNT_W'(hi), exp_mc});
    endtask

    task automatic rise_edge(input bit exp_v, input int per, input int hi);
        sig_in = 1'b1;
        if (exp_v) push_exp(per, hi);
    endtask

    task automatic fall_edge();
        sig_in = 1'b0;
    endtask

    // n periods of a per/hi wave; rise 0 reports (fper, fhi) if first_exp.
    task automatic wave(input int n, input int per, input int hi,
                        input bit first_exp, input int fper, input int fhi);
        for (int i = 0; i < n; i++) begin
            if (i == 0) rise_edge(first_exp, fper, fhi);
            else        rise_edge(1'b1, per, hi);
            hold(hi);
            fall_edge();
            hold(per - hi);
        end
    endtask

    task automatic do_reset(input int n, input string tag);
        reset = 1'b1;
        hold(n);
        check({tag, "_period"},    period,    0);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_valid"},     valid,     0);
        check({tag, "_timeout"},   timeout,   0);
        check({tag, "_meas_cnt"},  meas_cnt,  0);
        reset  = 1'b0;
        exp_mc = '0;
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin
        logic             prev_valid;
        logic             prev_tmo;
        int               since_valid;
        logic [EXP_W-1:0] e;
        prev_valid  = 1'b0;
        prev_tmo    = 1'b0;
        since_valid = 0;
        forever begin
            @(negedge clk);
            if (valid) begin
                check("valid_width", prev_valid, 0);
                since_valid = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("period",    period,    e[EXP_W-1 -: CNT_W]);
                    check("high_time", high_time, e[EDGE_W +: CNT_W]);
                    check("meas_cnt",  meas_cnt,  e[EDGE_W-1:0]);
                    last_per = e[EXP_W-1 -: CNT_W];
                    last_hi  = e[EDGE_W +: CNT_W];
                end
            end else begin
                since_valid++;
            end
            if (timeout && !prev_tmo && !reset) begin
                tmo_rises++;
                check("timeout_latency",   since_valid, TMO);
                check("timeout_period",    period,      last_per);
                check("timeout_high_time", high_time,   last_hi);
            end
            prev_valid = valid;
            prev_tmo   = timeout;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int tr0;
        @(negedge clk);

        // Reset with sig_in low, then a 10/4 wave.
        do_reset(3, "rst_init");
        hold(8);
        wave(5, 10, 4, 1'b0, 0, 0);

        // Stop the input low: timeout must rise TMO cycles after the last valid.
        tr0 = tmo_rises;
        hold(30);
        check("timeout_level",      timeout,         1);
        check("timeout_rise_count", tmo_rises - tr0, 1);

        // First rise leaves LOST silently, the next one measures again.
        wave(2, 10, 4, 1'b0, 0, 0);
        check("timeout_cleared", timeout, 0);

        // Period exactly TMO: rise and timeout coincide, rise wins.
        tr0 = tmo_rises;
        wave(3, 20, 5, 1'b1, 10, 4);
        rise_edge(1'b1, 20, 5);
        hold(3);
        check("boundary_no_timeout", tmo_rises - tr0, 0);
        check("boundary_timeout",    timeout,         0);

        // One-cycle reset in the middle of the high phase.
        do_reset(1, "rst_mid");
        fall_edge();
        hold(6);
        wave(3, 10, 4, 1'b0, 0, 0);

        // sig_in high through reset release, then wrap meas_cnt with 9 valids.
        sig_in = 1'b1;
        do_reset(3, "rst_high");
        hold(12);
        fall_edge();
        hold(6);
        wave(10, 10, 4, 1'b0, 0, 0);

        // Drain outstanding expectations with a bounded wait.
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_period_meter
